result_bcd_converter: RTL

Sequential binary-to-BCD converter placed directly downstream of the calculator's registered result stage. It consumes the 2*width-bit result word and its sign flag, and converts the magnitude to packed BCD digits using shift-and-add-3 (double-dabble), one bit per clock. The digits feed the display driver. A start/busy/done handshake lets the controlling FSM launch a conversion once the result registers are written.

---
 rtl/calc_pkg.sv | 25 ++
 rtl/result_bcd_converter_if.sv | 23 ++
 rtl/bcd_add3_digit.sv | 7 +
 rtl/result_bcd_converter.sv | 108 ++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the result-to-BCD conversion path.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int bcd_digits(input int width);
    longint unsigned max_val;
    longint unsigned lim;
    int d;
    max_val = (longint'(1) << width) - 1;
    lim = 10;
    d = 1;
    for (int i = 0; i < 20; i++) begin
      if (lim <= max_val) begin
        lim = lim * 10;
        d = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/result_bcd_converter_if.sv
// Start/busy/done handshake plus data between the result stage and the BCD converter.
interface result_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start_i;
  logic [WIDTH-1:0]      value_i;
  logic                  sign_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*DIGITS-1:0]   bcd_o;
  logic                  sign_o;

  modport master (
    output start_i, value_i, sign_i,
    input  busy_o, done_o, bcd_o, sign_o
  );

  modport slave (
    input  start_i, value_i, sign_i,
    output busy_o, done_o, bcd_o, sign_o
  );
endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);
  assign corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Define LEADING_ZERO_BLANK_EN to replace leading zero digits above digit 0 with the blank code.
//
// state | meaning
// IDLE  | waiting for start_i; captures value/sign on start
// SHIFT | one add-3/shift step per cycle, WIDTH cycles
// DONE  | one cycle; publishes bcd_o/sign_o and done_o on the closing edge
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = bcd_digits(WIDTH)
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  result_bcd_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  bcd_state_t            state_q, state_d;
  logic [4*DIGITS-1:0]   work_q, work_fix, bcd_next, bcd_q;
  logic [WIDTH-1:0]      bin_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  sign_hold_q, sign_q, done_q;
  logic                  busy, load_start, shift_en, load_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit     (work_q[4*g +: 4]),
      .corrected (work_fix[4*g +: 4])
    );
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    load_start = (state_q == IDLE) && bus.start_i;
    shift_en   = (state_q == SHIFT);
    load_out   = (state_q == DONE);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      work_q      <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      sign_hold_q <= 1'b0;
    end else if (load_start) begin
      work_q      <= '0;
      bin_q       <= bus.value_i;
      cnt_q       <= CNT_W'(WIDTH);
      sign_hold_q <= bus.sign_i;
    end else if (shift_en) begin
      {work_q, bin_q} <= {work_fix, bin_q} << 1;
      cnt_q           <= cnt_q - CNT_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; stop blanking at the first non-zero digit.
  always_comb begin
    logic leading;
    leading  = 1'b1;
    bcd_next = work_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (leading && (work_q[4*i +: 4] == 4'd0)) bcd_next[4*i +: 4] = BCD_BLANK;
      else                                       leading = 1'b0;
    end
  end
`else
  assign bcd_next = work_q;
`endif

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      done_q <= 1'b0;
      bcd_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      done_q <= load_out;
      if (load_out) begin
        bcd_q  <= bcd_next;
        sign_q <= sign_hold_q;
      end
    end
  end

  assign bus.busy_o = busy;
  assign bus.done_o = done_q;
  assign bus.bcd_o  = bcd_q;
  assign bus.sign_o = sign_q;

endmodule
